peripheral_ahb3_spram_ws: RTL
=============================

Name: peripheral_ahb3_spram_ws

Overview:
AHB3-Lite single-port RAM slave, successor to the fixed-timing AHB3 SPRAM. Adds parametrised wait states, byte-lane writes from HSIZE/HADDR, read-after-write forwarding and a two-cycle ERROR response for illegal accesses. Sits on the peripheral AHB3 interconnect as a memory-mapped scratchpad.

Parameters:
XLEN, 64, data bus width in bits (32 or 64)
PLEN, 64, address bus width in bits
MEM_DEPTH, 256, number of XLEN-bit words
WAIT_STATES, 0, stall cycles (HREADYOUT=0) inserted per OKAY transfer (0..15)
TECHNOLOGY, "GENERIC", RAM macro selector; only GENERIC is required

Ports:
HCLK  in  1  clock
HRESETn  in  1  reset, asynchronous, active-low
HSEL  in  1  slave select
HADDR  in  PLEN  byte address
HWDATA  in  XLEN  write data (data phase)
HRDATA  out  XLEN  read data
HWRITE  in  1  1=write
HSIZE  in  3  transfer size, log2 bytes
HBURST  in  3  burst type (ignored; each beat handled independently)
HPROT  in  4  protection (ignored)
HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
HMASTLOCK  in  1  lock (ignored)
HREADYOUT  out  1  slave ready
HREADY  in  1  bus ready (combined)
HRESP  out  1  0=OKAY, 1=ERROR

Behaviour:
- One clock HCLK; reset HRESETn asynchronous, active-low. Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, wait counter 0. RAM contents not reset.
- Accept address phase when HSEL & HREADY & HTRANS[1]. IDLE/BUSY or HSEL=0: no access; next cycle HREADYOUT=1, HRESP=0.
- Illegal if any: HADDR >= MEM_DEPTH*XLEN/8; HSIZE > log2(XLEN/8); HADDR not aligned to 2^HSIZE.
- Word index = HADDR[log2(XLEN/8) +: log2(MEM_DEPTH)]. Byte enables = (2^(2^HSIZE))-1 shifted left by HADDR[log2(XLEN/8)-1:0].
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  IDLE --legal accept, WAIT_STATES>0--> WAIT (counter=WAIT_STATES-1, HREADYOUT=0).
  IDLE --legal accept, WAIT_STATES=0--> DATA (HREADYOUT=1).
  WAIT: decrement; at 0 --> DATA.
  DATA: transfer completes this cycle; new accept re-enters WAIT/DATA/ERR1, otherwise --> IDLE.
  Illegal accept --> ERR1 (HREADYOUT=0, HRESP=1) --> ERR2 (HREADYOUT=1, HRESP=1) --> IDLE. ERR2 may accept a new address phase (follow as IDLE). Illegal access never touches RAM.
- Write: HWDATA sampled in DATA cycle; enabled bytes written at end of that cycle; other bytes unchanged.
- Read: RAM read launched with latched word index; HRDATA valid (full word, all lanes) in DATA cycle, held until next read completes. Total read latency = 1+WAIT_STATES cycles after address phase.
- Forwarding: if a read address phase is accepted in the same cycle a write completes (DATA) to the same word, returned HRDATA merges the written bytes over RAM data. No stale data at any WAIT_STATES.
- Back-to-back pipelined transfers supported: address phase of N+1 overlaps DATA cycle of N.
- Reset asserted mid-transfer: transfer aborted, pending write not performed, outputs to reset values immediately.
- HREADY=0 in IDLE (other slave stalling): no accept, HREADYOUT=1.

Test Plan:
- WAIT_STATES=0: write 0x1122334455667788 at 0x10 (HSIZE=3), read 0x10 next cycle -> HRDATA=0x1122334455667788 in first data cycle, HRESP=0, forwarding path exercised.
- Byte write 0xAA at 0x13 (HSIZE=0) over 0x1122334455667788 -> read 0x10 returns 0x11223344AA667788.
- WAIT_STATES=2: read 0x08 -> HREADYOUT low exactly 2 cycles, then high with data, HRESP=0.
- Read 0x800 (MEM_DEPTH=256, XLEN=64, out of range) -> ERR1: HREADYOUT=0,HRESP=1; ERR2: HREADYOUT=1,HRESP=1; RAM unchanged.
- Misaligned HSIZE=2 write at 0x02 -> two-cycle ERROR, subsequent read 0x00 returns prior contents.
- Assert HRESETn=0 during WAIT of a write to 0x20 (WAIT_STATES=3) -> HREADYOUT=1, HRESP=0, HRDATA=0 at once; later read 0x20 shows old value.

Source files
------------

// File: rtl/peripheral_ahb3_spram_ws.sv
// AHB3-Lite single-port RAM slave with WAIT_STATES stall cycles, byte-lane writes, RAW forwarding and 2-cycle ERROR.
// Read data lands in the DATA cycle, 1+WAIT_STATES cycles after the address phase; HREADYOUT low during WAIT/ERR1.
module peripheral_ahb3_spram_ws #(
   parameter int XLEN        = 64,
   parameter int PLEN        = 64,
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_STATES = 0,
   parameter     TECHNOLOGY  = "GENERIC"
) (
   input  logic            HCLK,
   input  logic            HRESETn,
   input  logic            HSEL,
   input  logic [PLEN-1:0] HADDR,
   input  logic [XLEN-1:0] HWDATA,
   output logic [XLEN-1:0] HRDATA,
   input  logic            HWRITE,
   input  logic [2:0]      HSIZE,
   input  logic [2:0]      HBURST,
   input  logic [3:0]      HPROT,
   input  logic [1:0]      HTRANS,
   input  logic            HMASTLOCK,
   output logic            HREADYOUT,
   input  logic            HREADY,
   output logic            HRESP
);

   localparam int BW    = XLEN / 8;
   localparam int ABITS = $clog2(BW);
   localparam int WBITS = $clog2(MEM_DEPTH);
   localparam logic [PLEN-1:0] MEM_BYTES = PLEN'(MEM_DEPTH * BW);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [WBITS-1:0]  widx_q, widx_d;
   logic [BW-1:0]     be_q, be_d;
   logic              write_q, write_d;
   logic [XLEN-1:0]   rdata_q, rdata_d;
   logic [XLEN-1:0]   mem [MEM_DEPTH];

   logic              accept, illegal, fwd;
   logic [ABITS-1:0]  a_off;
   logic [WBITS-1:0]  a_idx;
   logic [BW-1:0]     a_be;
   logic [XLEN-1:0]   rd_word;
   logic              unused_ok;

   assign a_off   = HADDR[ABITS-1:0];
   assign a_idx   = HADDR[ABITS +: WBITS];
   assign accept  = (state_q == S_IDLE || state_q == S_DATA || state_q == S_ERR2)
                    && HSEL && HREADY && HTRANS[1];
   assign illegal = (HADDR >= MEM_BYTES) || (HSIZE > 3'(ABITS))
                    || ((a_off & ABITS'((1 << HSIZE) - 1)) != '0);
   assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], (TECHNOLOGY == "GENERIC")};

   always_comb begin
      a_be = '0;
      for (int b = 0; b < BW; b++)
         a_be[b] = (b >= int'(a_off)) && (b < int'(a_off) + (1 << HSIZE));
   end

   // A write finishing in the same cycle a read to its word is accepted has not reached the RAM yet.
   always_comb begin
      rd_word = (state_q == S_WAIT) ? mem[widx_q] : mem[a_idx];
      fwd     = (state_q == S_DATA) && write_q && (widx_q == a_idx);
      for (int b = 0; b < BW; b++)
         if (fwd && be_q[b]) rd_word[b*8 +: 8] = HWDATA[b*8 +: 8];
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         widx_q  <= '0;
         be_q    <= '0;
         write_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         widx_q  <= widx_d;
         be_q    <= be_d;
         write_q <= write_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      widx_d  = widx_q;
      be_d    = be_q;
      write_d = write_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE, S_DATA, S_ERR2: begin
            state_d = S_IDLE;
            if (accept) begin
               if (illegal) begin
                  state_d = S_ERR1;
               end else begin
                  widx_d  = a_idx;
                  be_d    = a_be;
                  write_d = HWRITE;
                  if (WAIT_STATES > 0) begin
                     state_d = S_WAIT;
                     cnt_d   = 4'(WAIT_STATES - 1);
                  end else begin
                     state_d = S_DATA;
                     if (!HWRITE) rdata_d = rd_word;
                  end
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_DATA;
               if (!write_q) rdata_d = rd_word;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_ERR1:  state_d = S_ERR2;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      HREADYOUT = 1'b1;
      HRESP     = 1'b0;
      case (state_q)
         S_WAIT: HREADYOUT = 1'b0;
         S_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = 1'b1;
         end
         S_ERR2: HRESP = 1'b1;
         default: ;
      endcase
   end

   assign HRDATA = rdata_q;

   always_ff @(posedge HCLK) begin
      if (state_q == S_DATA && write_q)
         for (int b = 0; b < BW; b++)
            if (be_q[b]) mem[widx_q][b*8 +: 8] <= HWDATA[b*8 +: 8];
   end

endmodule
